// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic array sequencer slice.
package tpu_pkg;

    localparam int FP8_W     = 8;
    localparam int BF16_W    = 16;
    localparam int N_DEFAULT = 4;

    localparam logic [FP8_W-1:0] FP8_ZERO = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/systolic_seq_if.sv
// Result stream port of the sequencer: one captured accumulator row per beat.
interface systolic_seq_if #(
    parameter int N = 4
);
    import tpu_pkg::*;

    localparam int RW = (N > 1) ? $clog2(N) : 1;

    // A beat transfers on a rising clk edge where res_valid && res_ready.
    // Once res_valid is high, res_data/res_row/res_last stay stable until
    // that transfer; res_valid never drops without a transfer.
    logic                  res_valid;
    logic                  res_ready;
    logic [N*BF16_W-1:0]   res_data;
    logic [RW-1:0]         res_row;
    logic                  res_last;

    modport master (
        output res_valid,
        output res_data,
        output res_row,
        output res_last,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_row,
        input  res_last,
        output res_ready
    );

endinterface

// File: rtl/skew_line.sv
// DEPTH-stage operand delay line with a valid tag; output is zero whenever
// the tag at the tap is clear. DEPTH=0 is a gated wire.
module skew_line
    import tpu_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FP8_W-1:0] din,
    input  logic             vin,
    output logic [FP8_W-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign dout = vin ? din : FP8_ZERO;
    end else begin : g_pipe
        logic [FP8_W-1:0] data_q [DEPTH];
        logic [DEPTH-1:0] vld_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                for (int s = 0; s < DEPTH; s++) begin
                    data_q[s] <= FP8_ZERO;
                end
            end else begin
                // Bubbles are stored as zero so idle stages do not toggle.
                vld_q[0]  <= vin;
                data_q[0] <= vin ? din : FP8_ZERO;
                for (int s = 1; s < DEPTH; s++) begin
                    vld_q[s]  <= vld_q[s-1];
                    data_q[s] <= data_q[s-1];
                end
            end
        end

        assign dout = vld_q[DEPTH-1] ? data_q[DEPTH-1] : FP8_ZERO;
    end

endmodule

// File: rtl/systolic_seq.sv
// Tile sequencer for an N x N output-stationary FP8/BF16 array: operand
// fetch and skew, diagonal clear/capture waves, and row-wise result drain.
module systolic_seq
    import tpu_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int KW = 8,
    parameter int AW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    output logic                  busy,
    output logic                  done,
    output logic                  a_rd_en,
    output logic [AW-1:0]         a_rd_addr,
    input  logic [N*FP8_W-1:0]    a_rd_data,
    output logic                  b_rd_en,
    output logic [AW-1:0]         b_rd_addr,
    input  logic [N*FP8_W-1:0]    b_rd_data,
    output logic [N*FP8_W-1:0]    a_lane,
    output logic [N*FP8_W-1:0]    b_lane,
    output logic [N*N-1:0]        pe_clear,
    input  logic [N*N*BF16_W-1:0] c_flat,
    systolic_seq_if.master        res,
    output seq_state_t            fsm_state
);

    localparam int CW = KW + $clog2(N) + 2;
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    seq_state_t    state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [KW-1:0] k_q, k_d;
    logic [RW-1:0] row_q, row_d;
    logic          done_q, done_d;
    logic          tag_q;
    logic          rd_en;
    logic [CW-1:0] k_ext;
    logic [CW-1:0] run_last;

    logic [BF16_W-1:0]   cap [N][N];
    logic [N*BF16_W-1:0] res_data_c;

    assign k_ext    = CW'(k_q);
    assign run_last = k_ext + CW'(2*N - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            k_q     <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
            tag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            k_q     <= k_d;
            row_q   <= row_d;
            done_q  <= done_d;
            tag_q   <= rd_en;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        k_d     = k_q;
        row_d   = row_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        k_d     = k_len;
                        cyc_d   = '0;
                        state_d = RUN;
                    end else begin
                        // Empty tile: report completion without touching the buffers.
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                cyc_d = cyc_q + CW'(1);
                if (cyc_q == run_last) begin
                    state_d = OUT;
                    row_d   = '0;
                end
            end
            OUT: begin
                if (res.res_ready) begin
                    if (row_q == RW'(N - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign fsm_state = state_q;

    assign rd_en     = (state_q == RUN) && (cyc_q < k_ext);
    assign a_rd_en   = rd_en;
    assign b_rd_en   = rd_en;
    assign a_rd_addr = rd_en ? AW'(cyc_q[KW-1:0]) : '0;
    assign b_rd_addr = rd_en ? AW'(cyc_q[KW-1:0]) : '0;

    // Lane i of A and lane j of B are delayed by i and j stages respectively.
    for (genvar g = 0; g < N; g++) begin : g_skew
        skew_line #(.DEPTH(g)) u_a_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (a_rd_data[FP8_W*g +: FP8_W]),
            .vin  (tag_q),
            .dout (a_lane[FP8_W*g +: FP8_W])
        );
        skew_line #(.DEPTH(g)) u_b_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (b_rd_data[FP8_W*g +: FP8_W]),
            .vin  (tag_q),
            .dout (b_lane[FP8_W*g +: FP8_W])
        );
    end

    // PE(i,j) sees its first pair at cyc i+j+1, so clearing during cyc i+j
    // lands on the edge just before it.
    for (genvar gi = 0; gi < N; gi++) begin : g_clr_row
        for (genvar gj = 0; gj < N; gj++) begin : g_clr_col
            assign pe_clear[gi*N + gj] = (state_q == RUN) && (cyc_q == CW'(gi + gj));
        end
    end

    // PE(i,j) takes its last real pair during cyc K+i+j; its accumulator
    // holds the final sum throughout cyc K+1+i+j.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    cap[i][j] <= '0;
                end
            end
        end else if (state_q == RUN) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (cyc_q == k_ext + CW'(i + j + 1)) begin
                        cap[i][j] <= c_flat[BF16_W*(i*N + j) +: BF16_W];
                    end
                end
            end
        end
    end

    always_comb begin
        res_data_c = '0;
        if (state_q == OUT) begin
            for (int j = 0; j < N; j++) begin
                res_data_c[BF16_W*j +: BF16_W] = cap[row_q][j];
            end
        end
    end

    assign res.res_valid = (state_q == OUT);
    assign res.res_data  = res_data_c;
    assign res.res_row   = (state_q == OUT) ? row_q : '0;
    assign res.res_last  = (state_q == OUT) && (row_q == RW'(N - 1));

endmodule

// File: tb/tb_systolic_seq.sv
// Bench for systolic_seq: operand SRAM model, randomized accumulator stub
// and a tile-level reference model with a row scoreboard.
module tb_systolic_seq;
    import tpu_pkg::*;

    localparam int N   = 4;
    localparam int KW  = 8;
    localparam int AW  = 8;
    localparam int LW  = N * 8;
    localparam int CFW = N * N * 16;
    localparam int RDW = N * 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [KW-1:0]  k_len;
    logic           busy;
    logic           done;
    logic           a_rd_en;
    logic [AW-1:0]  a_rd_addr;
    logic [LW-1:0]  a_rd_data;
    logic           b_rd_en;
    logic [AW-1:0]  b_rd_addr;
    logic [LW-1:0]  b_rd_data;
    logic [LW-1:0]  a_lane;
    logic [LW-1:0]  b_lane;
    logic [N*N-1:0] pe_clear;
    logic [CFW-1:0] c_flat;
    seq_state_t     fsm_state;

    systolic_seq_if #(.N(N)) res_if ();

    systolic_seq #(.N(N), .KW(KW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .done      (done),
        .a_rd_en   (a_rd_en),
        .a_rd_addr (a_rd_addr),
        .a_rd_data (a_rd_data),
        .b_rd_en   (b_rd_en),
        .b_rd_addr (b_rd_addr),
        .b_rd_data (b_rd_data),
        .a_lane    (a_lane),
        .b_lane    (b_lane),
        .pe_clear  (pe_clear),
        .c_flat    (c_flat),
        .res       (res_if),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int n_total = 0;
    int n_pass  = 0;
    bit pending_done = 1'b0;

    logic [LW-1:0]  a_mem   [256];
    logic [LW-1:0]  b_mem   [256];
    logic [CFW-1:0] chist   [1024];
    logic [7:0]     obs_a2  [1024];
    logic [7:0]     obs_b3  [1024];
    logic [RDW-1:0] obs_rows[N];
    logic [RDW-1:0] exp_q   [$];

    // Advance one cycle; the SRAM returns data for the request seen before
    // the edge, everything else gets fresh junk.
    task automatic next_cycle();
        logic          a_en, b_en;
        logic [AW-1:0] a_ad, b_ad;
        a_en = a_rd_en; a_ad = a_rd_addr;
        b_en = b_rd_en; b_ad = b_rd_addr;
        @(posedge clk);
        #1;
        a_rd_data = a_en ? a_mem[a_ad] : $urandom;
        b_rd_data = b_en ? b_mem[b_ad] : $urandom;
        for (int w = 0; w < CFW/32; w++) c_flat[32*w +: 32] = $urandom;
        res_if.res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic fill_random_mem();
        for (int k = 0; k < 256; k++) begin
            a_mem[k] = $urandom;
            b_mem[k] = $urandom;
        end
    endtask

    task automatic fill_directed_mem();
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < N; i++) begin
                a_mem[k][8*i +: 8] = 8'(8'h10 * k + i);
                b_mem[k][8*i +: 8] = 8'(8'h80 + 8'h10 * k + i);
            end
        end
    endtask

    // One full tile. ready_mode: 0 = always ready, 1 = random, 2 = fixed stall pattern.
    // abort_t >= 0 asserts reset during that RUN cycle and ends the tile there.
    task automatic run_tile(input int k, input int ready_mode, input bit pattern_c, input int abort_t);
        logic [LW-1:0]  exp_a, exp_b;
        logic [N*N-1:0] exp_clr;
        logic [RDW-1:0] row;
        int             kk, ocyc, rows, n_bad;
        int             clr_cnt [N*N];
        bit             ready;
        bit             pat [8] = '{0, 0, 0, 1, 0, 1, 1, 1};

        for (int p = 0; p < N*N; p++) clr_cnt[p] = 0;

        start = 1'b1;
        k_len = KW'(k);
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || done !== pending_done)
            $display("FAIL start_cycle: busy=%b done=%b expected busy=0 done=%b", busy, done, pending_done);
        else n_pass++;
        pending_done = 1'b0;
        next_cycle();
        start = 1'b0;
        k_len = KW'($urandom);

        for (int t = 0; t < k + 2*N; t++) begin
            if (pattern_c) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        c_flat[16*(i*N+j) +: 16] = {i[3:0], j[3:0], t[7:0]};
            end
            chist[t] = c_flat;

            if (t == abort_t) begin
                rst = 1'b1;
                #1;
                n_total++;
                if (busy !== 1'b0 || done !== 1'b0 || a_rd_en !== 1'b0 || b_rd_en !== 1'b0 ||
                    a_rd_addr !== '0 || b_rd_addr !== '0 || pe_clear !== '0 || fsm_state !== IDLE)
                    $display("FAIL abort_ctrl: busy=%b done=%b rd=%b%b addr=%h/%h clr=%h state=%0d expected all zero",
                             busy, done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, pe_clear, fsm_state);
                else n_pass++;
                n_total++;
                if (a_lane !== '0 || b_lane !== '0 || res_if.res_valid !== 1'b0 || res_if.res_data !== '0 ||
                    res_if.res_row !== '0 || res_if.res_last !== 1'b0)
                    $display("FAIL abort_data: a_lane=%h b_lane=%h valid=%b data=%h row=%0d last=%b expected all zero",
                             a_lane, b_lane, res_if.res_valid, res_if.res_data, res_if.res_row, res_if.res_last);
                else n_pass++;
                @(negedge clk);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                next_cycle();
                pending_done = 1'b0;
                return;
            end

            if ($urandom_range(0, 5) == 0) begin
                start = 1'b1;
                k_len = KW'($urandom);
            end

            exp_a = '0;
            exp_b = '0;
            for (int i = 0; i < N; i++) begin
                kk = t - 1 - i;
                if (kk >= 0 && kk < k) begin
                    exp_a[8*i +: 8] = a_mem[kk][8*i +: 8];
                    exp_b[8*i +: 8] = b_mem[kk][8*i +: 8];
                end
            end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    exp_clr[i*N+j] = (t == i + j);

            @(negedge clk);
            obs_a2[t] = a_lane[23:16];
            obs_b3[t] = b_lane[31:24];
            for (int p = 0; p < N*N; p++) if (pe_clear[p] === 1'b1) clr_cnt[p]++;

            n_total++;
            if (busy !== 1'b1 || done !== 1'b0 || res_if.res_valid !== 1'b0 || fsm_state !== RUN)
                $display("FAIL run_status t=%0d: busy=%b done=%b valid=%b state=%0d expected 1/0/0/RUN",
                         t, busy, done, res_if.res_valid, fsm_state);
            else n_pass++;
            n_total++;
            if ({a_rd_en, b_rd_en} !== {2{t < k}})
                $display("FAIL rd_en t=%0d: got %b%b expected %b", t, a_rd_en, b_rd_en, (t < k));
            else n_pass++;
            if (t < k) begin
                n_total++;
                if (a_rd_addr !== AW'(t) || b_rd_addr !== AW'(t))
                    $display("FAIL rd_addr t=%0d: got %0d/%0d expected %0d", t, a_rd_addr, b_rd_addr, t);
                else n_pass++;
            end
            n_total++;
            if (a_lane !== exp_a)
                $display("FAIL a_lane t=%0d: got %h expected %h", t, a_lane, exp_a);
            else n_pass++;
            n_total++;
            if (b_lane !== exp_b)
                $display("FAIL b_lane t=%0d: got %h expected %h", t, b_lane, exp_b);
            else n_pass++;
            n_total++;
            if (pe_clear !== exp_clr)
                $display("FAIL pe_clear t=%0d: got %h expected %h", t, pe_clear, exp_clr);
            else n_pass++;

            next_cycle();
            start = 1'b0;
        end

        n_bad = 0;
        for (int p = 0; p < N*N; p++) if (clr_cnt[p] != 1) n_bad++;
        n_total++;
        if (n_bad != 0)
            $display("FAIL clear_once: %0d PEs without exactly one clear cycle, expected 0", n_bad);
        else n_pass++;

        exp_q.delete();
        for (int r = 0; r < N; r++) begin
            row = '0;
            for (int j = 0; j < N; j++)
                row[16*j +: 16] = chist[k + 1 + r + j][16*(r*N+j) +: 16];
            exp_q.push_back(row);
        end

        ocyc = 0;
        rows = 0;
        while (exp_q.size() > 0 && ocyc < 200) begin
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = (ocyc < 8) ? pat[ocyc] : 1'b1;
            endcase
            res_if.res_ready = ready;
            @(negedge clk);
            n_total++;
            if (res_if.res_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || a_rd_en !== 1'b0 || pe_clear !== '0)
                $display("FAIL out_status row=%0d: valid=%b busy=%b done=%b rd=%b clr=%h expected 1/1/0/0/0",
                         rows, res_if.res_valid, busy, done, a_rd_en, pe_clear);
            else n_pass++;
            n_total++;
            if (res_if.res_row !== 2'(rows) || res_if.res_last !== (rows == N-1))
                $display("FAIL res_row: got row=%0d last=%b expected row=%0d last=%b",
                         res_if.res_row, res_if.res_last, rows, (rows == N-1));
            else n_pass++;
            n_total++;
            if (res_if.res_data !== exp_q[0])
                $display("FAIL res_data row=%0d: got %h expected %h", rows, res_if.res_data, exp_q[0]);
            else n_pass++;
            if (ready) begin
                obs_rows[rows] = res_if.res_data;
                void'(exp_q.pop_front());
                rows++;
            end
            next_cycle();
            ocyc++;
        end
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL out_timeout: %0d rows left, expected 0", exp_q.size());
        else n_pass++;
        pending_done = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            start = 1'b0;
            @(negedge clk);
            n_total++;
            if (busy !== 1'b0 || done !== pending_done || res_if.res_valid !== 1'b0 ||
                a_rd_en !== 1'b0 || b_rd_en !== 1'b0 || pe_clear !== '0 || a_lane !== '0 || b_lane !== '0)
                $display("FAIL idle: busy=%b done=%b valid=%b rd=%b%b clr=%h lanes=%h/%h expected 0 done=%b",
                         busy, done, res_if.res_valid, a_rd_en, b_rd_en, pe_clear, a_lane, b_lane, pending_done);
            else n_pass++;
            pending_done = 1'b0;
            next_cycle();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        k_len = '0;
        a_rd_data = '0;
        b_rd_data = '0;
        c_flat = '0;
        res_if.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || fsm_state !== IDLE)
            $display("FAIL reset_ctrl: busy=%b done=%b state=%0d expected 0/0/IDLE", busy, done, fsm_state);
        else n_pass++;
        n_total++;
        if (a_rd_en !== 1'b0 || b_rd_en !== 1'b0 || a_rd_addr !== '0 || b_rd_addr !== '0)
            $display("FAIL reset_rd: en=%b%b addr=%h/%h expected zero", a_rd_en, b_rd_en, a_rd_addr, b_rd_addr);
        else n_pass++;
        n_total++;
        if (a_lane !== '0 || b_lane !== '0 || pe_clear !== '0)
            $display("FAIL reset_lanes: a=%h b=%h clr=%h expected zero", a_lane, b_lane, pe_clear);
        else n_pass++;
        n_total++;
        if (res_if.res_valid !== 1'b0 || res_if.res_data !== '0 || res_if.res_row !== '0 || res_if.res_last !== 1'b0)
            $display("FAIL reset_res: valid=%b data=%h row=%0d last=%b expected zero",
                     res_if.res_valid, res_if.res_data, res_if.res_row, res_if.res_last);
        else n_pass++;
        rst = 1'b0;
        next_cycle();
        idle_cycles(2);
    endtask

    task automatic test_skew_clear();
        logic [7:0] a2_exp [8] = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h22, 8'h00, 8'h00};
        logic [7:0] b3_exp [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h83, 8'h93, 8'hA3, 8'h00};
        fill_directed_mem();
        run_tile(3, 0, 1'b0, -1);
        idle_cycles(2);
        for (int t = 0; t < 8; t++) begin
            n_total++;
            if (obs_a2[t] !== a2_exp[t] || obs_b3[t] !== b3_exp[t])
                $display("FAIL skew_directed cyc=%0d: a_lane[2]=%h b_lane[3]=%h expected %h %h",
                         t, obs_a2[t], obs_b3[t], a2_exp[t], b3_exp[t]);
            else n_pass++;
        end
    endtask

    task automatic test_capture();
        fill_random_mem();
        run_tile(5, 0, 1'b1, -1);
        idle_cycles(1);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                n_total++;
                if (obs_rows[i][16*j +: 16] !== {i[3:0], j[3:0], 8'(6 + i + j)})
                    $display("FAIL capture PE(%0d,%0d): got %h expected %h", i, j,
                             obs_rows[i][16*j +: 16], {i[3:0], j[3:0], 8'(6 + i + j)});
                else n_pass++;
            end
        end
    endtask

    task automatic test_handshake();
        fill_random_mem();
        run_tile($urandom_range(1, 10), 2, 1'b0, -1);
        idle_cycles(3);
    endtask

    task automatic test_zero_k();
        start = 1'b1;
        k_len = '0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || a_rd_en !== 1'b0 || done !== pending_done)
            $display("FAIL zero_k_start: busy=%b rd=%b done=%b expected 0/0/%b", busy, a_rd_en, done, pending_done);
        else n_pass++;
        pending_done = 1'b0;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        n_total++;
        if (done !== 1'b1 || busy !== 1'b0 || a_rd_en !== 1'b0 || b_rd_en !== 1'b0)
            $display("FAIL zero_k_done: done=%b busy=%b rd=%b%b expected 1/0/00", done, busy, a_rd_en, b_rd_en);
        else n_pass++;
        next_cycle();
        idle_cycles(2);
    endtask

    task automatic test_abort();
        fill_random_mem();
        run_tile(6, 0, 1'b0, 4);
        idle_cycles(4);
        run_tile(4, 0, 1'b0, -1);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        fill_random_mem();
        run_tile(2, 0, 1'b0, -1);
        run_tile(7, 1, 1'b0, -1);
        run_tile(1, 0, 1'b1, -1);
        idle_cycles(2);
    endtask

    task automatic test_random();
        int k;
        for (int n = 0; n < 6; n++) begin
            fill_random_mem();
            k = (n == 5) ? 255 : $urandom_range(1, 40);
            run_tile(k, 1, 1'($urandom_range(0, 1)), -1);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_skew_clear();
        test_capture();
        test_handshake();
        test_zero_k();
        test_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/systolic_seq.md
Name: systolic_seq

Overview:
- Sequencer for an N x N output-stationary array of FP8 (E4M3) multiply / BF16-accumulate PEs.
- Reads one A-column vector and one B-row vector per cycle from the operand buffers, and applies diagonal skew to them.
- Drives per-PE clear in a diagonal wave, and snapshots each PE's BF16 accumulator on the exact cycle it completes.
- Streams the N x N result out row by row over a valid/ready port. Sits between the operand SRAMs/host and the PE array.

Parameters:
N, 4, array dimension (rows = columns = N)
KW, 8, width of the inner-dimension length k_len
AW, 8, operand buffer address width (must be >= KW)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  begin a tile; sampled only in IDLE
k_len  in  KW  inner dimension K; sampled with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at the end of a tile
a_rd_en  out  1  A buffer read strobe; data returns the next cycle
a_rd_addr  out  AW  A buffer address (k index)
a_rd_data  in  N*8  A column k; lane i in bits [8i+7:8i]
b_rd_en  out  1  B buffer read strobe; data returns the next cycle
b_rd_addr  out  AW  B buffer address (k index)
b_rd_data  in  N*8  B row k; lane j in bits [8j+7:8j]
a_lane  out  N*8  skewed west-edge operands; lane i feeds array row i
b_lane  out  N*8  skewed north-edge operands; lane j feeds array column j
pe_clear  out  N*N  per-PE clear; bit i*N+j drives PE(i,j)
c_flat  in  N*N*16  PE accumulators; PE(i,j) at bits [16(i*N+j)+15 : 16(i*N+j)]
res_valid  out  1  result row available
res_ready  in  1  consumer accepts the row
res_data  out  N*16  captured row res_row; PE(r,j) in lane j
res_row  out  log2(N)  row index of res_data
res_last  out  1  high with res_valid when res_row == N-1

Behaviour:
- Reset values: state IDLE; all outputs 0; capture buffer 0; skew lines 0.
- Reset asserted mid-tile aborts the tile immediately. No done pulse is produced.
- States: IDLE, RUN, OUT.
- IDLE:
  - start=1 with k_len>0: latch K, set cyc=0, go to RUN.
  - start=1 with k_len==0: stay in IDLE, pulse done on the next cycle, do not read.
- RUN, free-running cyc counter (width KW+log2(N)+2, no wrap possible):
  - Reads: a_rd_en = b_rd_en = (cyc < K); both addresses = cyc.
  - Read data arrives at cyc+1 with a valid tag. Lane i of A and lane j of B pass through skew lines of depth i and j.
  - Lane output is forced to 8'h00 whenever its tag is 0.
  - Result: PE(i,j) receives operand pair k during cycle cyc = k+1+i+j.
  - Clear wave: pe_clear[i*N+j] = 1 only during cyc == i+j. PE(i,j) is cleared on the edge before its first pair.
  - Capture wave: at the edge ending cyc == K+1+i+j, copy PE(i,j)'s c_flat slice into the capture buffer.
  - Go to OUT after the edge ending cyc == K+2N-1, the last diagonal. RUN lasts exactly K+2N cycles.
- Accumulation after capture: PEs keep accumulating zero-operand products. That is harmless because the captures are already taken.
- OUT:
  - res_valid=1, res_row starts at 0, res_data = capture row res_row.
  - res_data and res_row are held stable while res_valid && !res_ready.
  - Each handshake increments res_row.
  - The handshake with res_last returns to IDLE and pulses done in that first IDLE cycle.
  - start is accepted in that same cycle.
- start while busy is ignored. k_len is not re-sampled while busy.
- First res_valid occurs K+2N+1 cycles after the start edge, given res_ready is held high. Total tile time is K+3N+1 cycles.
- No arithmetic on BF16 values; the capture buffer is a pure data copy.

Decomposition:
- Shared package tpu_pkg holds:
  - FP8_W=8, BF16_W=16, default N;
  - the state enum {IDLE, RUN, OUT};
  - FP8 zero constant 8'h00.
- One sub-module: skew_line, a parameterised DEPTH x 8-bit shift register with a valid tag and zero-gating.
  - DEPTH=0 degenerates to a wire.
  - Instantiated 2N times.

Test Plan:
- N=4, K=3, A[k] lane i = 8'h10*k+i, B[k] lane j = 8'h80+8'h10*k+j -> a_lane[2] reads 00 until cyc 3, then 02,12,22, then 00; b_lane[3] shows 83,93,A3 at cyc 4..6.
- Same tile -> pe_clear bit 0 high only at cyc 0; bit 15 (PE(3,3)) only at cyc 6; exactly one high pulse per PE per tile.
- Stub array with c_flat PE(i,j) = {i[3:0], j[3:0], cyc[7:0]}, K=5 -> captured PE(i,j) low byte equals 6+i+j (cyc 6 for PE(0,0), cyc 12 for PE(3,3)).
- res_ready low 3 cycles, then toggled 1,0,1,1,1 -> 4 handshakes with rows 0,1,2,3, data stable while stalled, res_last only on row 3, done pulses once.
- k_len=0 start -> no rd_en, busy stays 0, done pulses next cycle; start pulsed during RUN -> ignored, cycle counts unchanged.
- rst asserted at cyc 4 of a tile -> all outputs 0 immediately, no done; a new tile afterwards matches the fresh-tile expectations.
